// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP master/slave handlers: sync byte,
// handler state encoding and frame/stream width helpers.
package sfp_pkg;

    localparam logic [7:0] SFP_SYNC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DELAY = 2'd2,
        SEND  = 2'd3
    } sfp_state_t;

    function automatic int frame_bits(input int word_w, input int n_words);
        return word_w * n_words;
    endfunction

    function automatic int stream_bits(input int word_w, input int n_words, input int n_slaves);
        return word_w * n_words * n_slaves;
    endfunction

endpackage

// File: rtl/sfp_watchdog.sv
// Link watchdog: saturating cycle counter, cleared by an accepted frame,
// frozen while disabled. Link-lost is asserted out of reset.
module sfp_watchdog #(
    parameter int C_TIMEOUT = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_link_lost
);

    localparam int CNT_W = $clog2(C_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_lost;

    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_lost <= 1'b1;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_lost <= 1'b0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt  <= w_cnt_nxt;
            r_lost <= r_lost | (w_cnt_nxt == CNT_MAX);
        end
    end

    assign o_link_lost = r_lost;

endmodule

// File: rtl/sfp_slave_handler.sv
// SFP slave: captures this slave's frame from the master stream, checks its
// header, forwards it to the AXI block and returns a response after a turnaround.
module sfp_slave_handler
    import sfp_pkg::*;
#(
    parameter int         C_AXIS_TDATA_WIDTH = 64,
    parameter int         C_NUMBER_OF_FRAME  = 6,
    parameter int         C_NUMBER_OF_SLAVE  = 3,
    parameter int         C_SLAVE_ID         = 0,
    parameter int         C_TX_DELAY         = 4,
    parameter int         C_TIMEOUT          = 100000,
    parameter logic [7:0] C_SYNC             = SFP_SYNC,
    localparam int FRAME_BIT  = frame_bits(C_AXIS_TDATA_WIDTH, C_NUMBER_OF_FRAME),
    localparam int STREAM_BIT = stream_bits(C_AXIS_TDATA_WIDTH, C_NUMBER_OF_FRAME, C_NUMBER_OF_SLAVE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sfp_s_en,
    input  logic [STREAM_BIT-1:0] i_stream_data,
    input  logic                  i_sfp_end_flag,
    input  logic                  i_sfp_tx_busy,
    output logic [FRAME_BIT-1:0]  o_axi_data,
    output logic                  o_rx_valid,
    input  logic [FRAME_BIT-1:0]  i_axi_data,
    output logic [FRAME_BIT-1:0]  o_stream_data,
    output logic                  o_sfp_start_flag,
    output logic [7:0]            o_rx_seq,
    output logic [15:0]           o_err_cnt,
    output logic                  o_link_lost,
    output logic [1:0]            o_debug_state
);

    localparam int W     = C_AXIS_TDATA_WIDTH;
    localparam int DLY_W = (C_TX_DELAY > 1) ? $clog2(C_TX_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(C_TX_DELAY - 1);

    sfp_state_t            r_state;
    sfp_state_t            w_state_nxt;
    logic [FRAME_BIT-1:0]  r_rx_buf;
    logic [FRAME_BIT-1:0]  r_axi_data;
    logic [FRAME_BIT-1:0]  r_stream_data;
    logic [7:0]            r_rx_seq;
    logic [15:0]           r_err_cnt;
    logic                  r_rx_valid;
    logic                  r_start;
    logic [DLY_W-1:0]      r_dly;

    logic [FRAME_BIT-1:0]  w_own_slice;
    logic [FRAME_BIT-1:0]  w_tx_frame;
    logic [7:0]            w_sync;
    logic [7:0]            w_seq;
    logic                  w_latch;
    logic                  w_accept;
    logic                  w_bad_sync;
    logic                  w_send;
    logic                  w_overrun;
    logic                  w_err_inc;
    logic                  w_unused;

    assign w_own_slice = i_stream_data[C_SLAVE_ID*FRAME_BIT +: FRAME_BIT];
    assign w_sync      = r_rx_buf[W-1 -: 8];
    assign w_seq       = r_rx_buf[W-9 -: 8];
    assign w_overrun   = i_sfp_s_en & i_sfp_end_flag & (r_state != IDLE);
    assign w_err_inc   = w_bad_sync | w_overrun;
    assign w_unused    = ^{i_stream_data, i_axi_data[W-1 -: 16]};

    // Response frame: payload from AXI with the header rewritten.
    always_comb begin
        w_tx_frame            = i_axi_data;
        w_tx_frame[W-1 -: 16] = {C_SYNC, r_rx_seq};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping enable aborts any transaction without emitting a start.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_accept    = 1'b0;
        w_bad_sync  = 1'b0;
        w_send      = 1'b0;
        if (!i_sfp_s_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_sfp_end_flag) begin
                        w_latch     = 1'b1;
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (w_sync == C_SYNC) begin
                        w_accept    = 1'b1;
                        w_state_nxt = DELAY;
                    end else begin
                        w_bad_sync  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                DELAY: begin
                    if (r_dly == '0) begin
                        w_state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (!i_sfp_tx_busy) begin
                        w_send      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_buf      <= '0;
            r_axi_data    <= '0;
            r_stream_data <= '0;
            r_rx_seq      <= '0;
            r_err_cnt     <= '0;
            r_rx_valid    <= 1'b0;
            r_start       <= 1'b0;
            r_dly         <= '0;
        end else begin
            r_rx_valid <= w_accept;
            r_start    <= w_send;
            if (w_latch) begin
                r_rx_buf <= w_own_slice;
            end
            if (w_accept) begin
                r_axi_data <= r_rx_buf;
                r_rx_seq   <= w_seq;
                r_dly      <= DLY_LOAD;
            end else if ((r_state == DELAY) && (r_dly != '0)) begin
                r_dly <= r_dly - 1'b1;
            end
            if (w_send) begin
                r_stream_data <= w_tx_frame;
            end
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    sfp_watchdog #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_watchdog (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_sfp_s_en),
        .i_clr       (w_accept),
        .o_link_lost (o_link_lost)
    );

    assign o_axi_data       = r_axi_data;
    assign o_rx_valid       = r_rx_valid;
    assign o_stream_data    = r_stream_data;
    assign o_sfp_start_flag = r_start;
    assign o_rx_seq         = r_rx_seq;
    assign o_err_cnt        = r_err_cnt;
    assign o_debug_state    = r_state;

endmodule

// File: tb/tb_sfp_slave_handler.sv
// Directed bench for sfp_slave_handler (slave 1 of 3, 4-cycle turnaround,
// 50-cycle watchdog) with hand-built frames and expected values.
module tb_sfp_slave_handler;

    localparam int FB = 64 * 6;
    localparam int SB = FB * 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic [SB-1:0] stream_in;
    logic          end_flag;
    logic          busy;
    logic [FB-1:0] axi_out;
    logic          rx_valid;
    logic [FB-1:0] axi_in;
    logic [FB-1:0] stream_out;
    logic          start_flag;
    logic [7:0]    rx_seq;
    logic [15:0]   err_cnt;
    logic          link_lost;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int n_valid, valid_edge, n_start, start_edge;

    sfp_slave_handler #(
        .C_SLAVE_ID (1),
        .C_TX_DELAY (4),
        .C_TIMEOUT  (50)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_sfp_s_en       (en),
        .i_stream_data    (stream_in),
        .i_sfp_end_flag   (end_flag),
        .i_sfp_tx_busy    (busy),
        .o_axi_data       (axi_out),
        .o_rx_valid       (rx_valid),
        .i_axi_data       (axi_in),
        .o_stream_data    (stream_out),
        .o_sfp_start_flag (start_flag),
        .o_rx_seq         (rx_seq),
        .o_err_cnt        (err_cnt),
        .o_link_lost      (link_lost),
        .o_debug_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FB-1:0] mk_frame(input logic [63:0] w0, input logic [7:0] tag);
        logic [FB-1:0] f;
        f[63:0] = w0;
        for (int k = 1; k < 6; k++) begin
            f[k*64 +: 64] = {tag, 48'h0, 8'(k)};
        end
        return f;
    endfunction

    function automatic logic [SB-1:0] mk_stream(input logic [FB-1:0] own);
        return {mk_frame(64'hA5DD_0000_0000_0D0D, 8'hDD), own,
                mk_frame(64'hA5EE_0000_0000_0E0E, 8'hEE)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic observe;
        if (rx_valid) begin
            n_valid++;
            valid_edge = edge_n;
        end
        if (start_flag) begin
            n_start++;
            start_edge = edge_n;
        end
    endtask

    task automatic pulse_end(input logic [SB-1:0] s);
        stream_in = s;
        end_flag  = 1'b1;
        tick();
        end_flag   = 1'b0;
        edge_n     = 0;
        n_valid    = 0;
        valid_edge = -1;
        n_start    = 0;
        start_edge = -1;
        observe();
    endtask

    logic [FB-1:0] frm_a, frm_d, rsp1, rsp3, rsp4;

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        stream_in = '0;
        end_flag  = 1'b0;
        busy      = 1'b0;
        axi_in    = '0;
        frm_a = mk_frame(64'hA517_0000_0000_1234, 8'h11);
        frm_d = mk_frame(64'hA533_0000_0000_0004, 8'h44);
        rsp1  = mk_frame(64'hA517_1111_2222_3333, 8'hC1);
        rsp3  = mk_frame(64'hA542_AAAA_BBBB_CCCC, 8'hC3);
        rsp4  = mk_frame(64'hA533_AAAA_BBBB_CCCC, 8'hC3);

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_state", dbg_state, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_lost", link_lost, 1);
        chk("rst_valid", rx_valid, 0);
        chk("rst_start", start_flag, 0);
        chk("rst_axi", axi_out, 0);
        chk("rst_stream", stream_out, 0);
        chk("rst_seq", rx_seq, 0);

        // Good frame, no busy
        en     = 1'b1;
        axi_in = mk_frame(64'hFFFF_1111_2222_3333, 8'hC1);
        pulse_end(mk_stream(frm_a));
        chk("s1_state_e0", dbg_state, 1);
        tick(); observe();
        chk("s1_state_e1", dbg_state, 2);
        chk("s1_axi", axi_out, frm_a);
        chk("s1_seq", rx_seq, 8'h17);
        chk("s1_lost_e1", link_lost, 0);
        for (int i = 0; i < 10; i++) begin
            tick(); observe();
        end
        chk("s1_valid_edge", valid_edge, 1);
        chk("s1_n_valid", n_valid, 1);
        chk("s1_start_edge", start_edge, 6);
        chk("s1_n_start", n_start, 1);
        chk("s1_stream", stream_out, rsp1);
        chk("s1_state_end", dbg_state, 0);
        while (edge_n < 50) tick();
        chk("s1_lost_e50", link_lost, 0);
        tick();
        chk("s1_lost_e51", link_lost, 1);

        // Bad sync byte
        pulse_end(mk_stream(mk_frame(64'h5A17_0000_0000_0002, 8'h22)));
        tick(); observe();
        chk("s2_state_e1", dbg_state, 0);
        for (int i = 0; i < 10; i++) begin
            tick(); observe();
        end
        chk("s2_err", err_cnt, 1);
        chk("s2_n_valid", n_valid, 0);
        chk("s2_n_start", n_start, 0);
        chk("s2_axi_hold", axi_out, frm_a);
        chk("s2_stream_hold", stream_out, rsp1);

        // TX busy for 10 cycles in SEND
        axi_in = mk_frame(64'h0000_AAAA_BBBB_CCCC, 8'hC3);
        busy   = 1'b1;
        pulse_end(mk_stream(mk_frame(64'hA542_0000_0000_0003, 8'h33)));
        for (int i = 0; i < 20; i++) begin
            tick(); observe();
            if (edge_n == 15) begin
                chk("s3_stream_stable", stream_out, rsp1);
                busy = 1'b0;
            end
        end
        chk("s3_start_edge", start_edge, 16);
        chk("s3_n_start", n_start, 1);
        chk("s3_stream", stream_out, rsp3);
        chk("s3_lost", link_lost, 0);

        // Overrun during DELAY
        pulse_end(mk_stream(frm_d));
        for (int i = 0; i < 12; i++) begin
            tick(); observe();
            if (edge_n == 2) begin
                stream_in = mk_stream(mk_frame(64'hA544_0000_0000_0005, 8'h55));
                end_flag  = 1'b1;
            end else begin
                end_flag = 1'b0;
            end
        end
        chk("s4_err", err_cnt, 2);
        chk("s4_n_valid", n_valid, 1);
        chk("s4_start_edge", start_edge, 6);
        chk("s4_n_start", n_start, 1);
        chk("s4_seq", rx_seq, 8'h33);
        chk("s4_axi", axi_out, frm_d);
        chk("s4_stream", stream_out, rsp4);

        // Enable dropped in DELAY
        pulse_end(mk_stream(mk_frame(64'hA555_0000_0000_0006, 8'h66)));
        for (int i = 0; i < 12; i++) begin
            tick(); observe();
            if (edge_n == 2) en = 1'b0;
            if (edge_n == 3) chk("s5_state_e3", dbg_state, 0);
        end
        chk("s5_n_start", n_start, 0);
        chk("s5_stream_hold", stream_out, rsp4);
        chk("s5_err", err_cnt, 2);

        // End pulse ignored while disabled
        pulse_end(mk_stream(frm_a));
        chk("s6_state_e0", dbg_state, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); observe();
        end
        chk("s6_n_valid", n_valid, 0);
        en = 1'b1;

        // Reset mid-transaction
        pulse_end(mk_stream(frm_a));
        for (int i = 0; i < 12; i++) begin
            tick(); observe();
            if (edge_n == 4) rst = 1'b1;
            if (edge_n == 5) rst = 1'b0;
        end
        chk("s7_n_start", n_start, 0);
        chk("s7_state", dbg_state, 0);
        chk("s7_err", err_cnt, 0);
        chk("s7_lost", link_lost, 1);
        chk("s7_axi", axi_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
